// File: rtl/view_data_unit.sv
// Front-panel viewer: shows a memory word/byte, a register or the PSW on four
// active-low 7-segment digits, with a debounced pushbutton that freezes the view.
module view_data_unit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_data,
    input  logic [15:0] reg_data,
    input  logic [15:0] psw_data,
    input  logic [15:0] addr,
    input  logic        view_btn,
    input  logic [1:0]  mem_mode,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [5:0]  LEDG,
    output logic [15:0] LEDR
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        VIEW_BYTE = 2'b00,
        VIEW_PSW  = 2'b01,
        VIEW_REG  = 2'b10,
        VIEW_WORD = 2'b11
    } view_mode_t;

    logic             btn_meta;
    logic             btn_sync;
    logic [1:0]       mode_meta;
    logic [1:0]       mode_sync;
    logic             btn_level;
    logic             btn_level_d;
    logic [CNT_W-1:0] db_cnt;
    logic             hold;
    view_mode_t       view_mode;
    logic [15:0]      value;
    logic [6:0]       next_hex0;
    logic [6:0]       next_hex1;
    logic [6:0]       next_hex2;
    logic [6:0]       next_hex3;
    logic [4:0]       psw_flags;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Buttons idle high, so the synchronizers reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta  <= 1'b1;
            btn_sync  <= 1'b1;
            mode_meta <= 2'b11;
            mode_sync <= 2'b11;
        end else begin
            btn_meta  <= view_btn;
            btn_sync  <= btn_meta;
            mode_meta <= mem_mode;
            mode_sync <= mode_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b1;
            db_cnt    <= '0;
        end else if (btn_sync == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            btn_level <= btn_sync;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Hold flips one cycle after the accepted level falls; releases are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level_d <= 1'b1;
            hold        <= 1'b0;
        end else begin
            btn_level_d <= btn_level;
            if (btn_level_d && !btn_level) begin
                hold <= ~hold;
            end
        end
    end

    assign view_mode = view_mode_t'(mode_sync);

    always_comb begin
        value = mem_data;
        case (view_mode)
            VIEW_REG: value = reg_data;
            VIEW_PSW: value = psw_data;
            default:  value = mem_data;
        endcase
        next_hex3 = seg7(value[15:12]);
        next_hex2 = seg7(value[11:8]);
        next_hex1 = seg7(value[7:4]);
        next_hex0 = seg7(value[3:0]);
        if (view_mode == VIEW_BYTE) begin
            next_hex3 = SEG_BLANK;
            next_hex2 = SEG_BLANK;
        end else if (view_mode == VIEW_REG && addr[3]) begin
            next_hex3 = SEG_DASH;
            next_hex2 = SEG_DASH;
            next_hex1 = SEG_DASH;
            next_hex0 = SEG_DASH;
        end
    end

    // Display registers only track the inputs while the view is not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HEX0      <= SEG_BLANK;
            HEX1      <= SEG_BLANK;
            HEX2      <= SEG_BLANK;
            HEX3      <= SEG_BLANK;
            LEDR      <= '0;
            psw_flags <= '0;
        end else if (!hold) begin
            HEX0      <= next_hex0;
            HEX1      <= next_hex1;
            HEX2      <= next_hex2;
            HEX3      <= next_hex3;
            LEDR      <= addr;
            psw_flags <= psw_data[4:0];
        end
    end

    assign LEDG = {hold, psw_flags};

endmodule

// File: tb/tb_view_data_unit.sv
// Directed bench for view_data_unit: view modes, sync latency, hold/debounce
// behaviour and asynchronous reset, all against hand-computed digit codes.
module tb_view_data_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] mem_data = '0;
    logic [15:0] reg_data = '0;
    logic [15:0] psw_data = '0;
    logic [15:0] addr = '0;
    logic        view_btn = 1'b1;
    logic [1:0]  mem_mode = 2'b11;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [5:0]  LEDG;
    logic [15:0] LEDR;

    int assertions = 0;
    int failures = 0;

    view_data_unit #(.DEBOUNCE_CYCLES(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_data (mem_data),
        .reg_data (reg_data),
        .psw_data (psw_data),
        .addr     (addr),
        .view_btn (view_btn),
        .mem_mode (mem_mode),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .LEDG     (LEDG),
        .LEDR     (LEDR)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] mode, input logic [15:0] mem,
                                  input logic [15:0] rdata, input logic [15:0] psw,
                                  input logic [15:0] a);
        mem_mode = mode;
        mem_data = mem;
        reg_data = rdata;
        psw_data = psw;
        addr     = a;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                             input logic [6:0] h1, input logic [6:0] h0);
        check_output({tag, "_hex3"}, 32'(HEX3), 32'(h3));
        check_output({tag, "_hex2"}, 32'(HEX2), 32'(h2));
        check_output({tag, "_hex1"}, 32'(HEX1), 32'(h1));
        check_output({tag, "_hex0"}, 32'(HEX0), 32'(h0));
    endtask

    task automatic press_button(input int cycles);
        view_btn = 1'b0;
        wait_cycles(cycles);
        view_btn = 1'b1;
    endtask

    initial begin
        apply_stimulus(2'b11, 16'h1A2F, 16'h0000, 16'h0000, 16'h0040);
        #1 rst_n = 1'b0;
        #1;
        check_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check_output("reset_ledg", 32'(LEDG), 32'h00);
        check_output("reset_ledr", 32'(LEDR), 32'h0000);

        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check_hex("word", 7'h79, 7'h08, 7'h24, 7'h0E);
        check_output("word_ledr", 32'(LEDR), 32'h0040);

        apply_stimulus(2'b10, 16'h1A2F, 16'hBEEF, 16'h0000, 16'h0003);
        wait_cycles(4);
        check_hex("reg3", 7'h03, 7'h06, 7'h06, 7'h0E);
        addr = 16'h0009;
        wait_cycles(2);
        check_hex("reg9", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        check_output("reg9_ledr", 32'(LEDR), 32'h0009);

        apply_stimulus(2'b01, 16'h1A2F, 16'hBEEF, 16'h0015, 16'h0009);
        wait_cycles(4);
        check_hex("psw", 7'h40, 7'h40, 7'h79, 7'h12);
        check_output("psw_ledg", 32'(LEDG), 32'h15);

        apply_stimulus(2'b00, 16'h12C7, 16'hBEEF, 16'h0015, 16'h0009);
        wait_cycles(4);
        check_hex("byte", 7'h7F, 7'h7F, 7'h46, 7'h78);

        // Mode change needs two sync stages plus the output register.
        mem_mode = 2'b11;
        wait_cycles(2);
        check_output("mode_lat2", 32'(HEX3), 32'h7F);
        wait_cycles(1);
        check_output("mode_lat3", 32'(HEX3), 32'h79);

        mem_data = 16'h1234;
        wait_cycles(2);
        check_hex("pre_hold", 7'h79, 7'h24, 7'h30, 7'h19);

        view_btn = 1'b0;
        wait_cycles(18);
        check_output("press_lat18", 32'(LEDG[5]), 32'h0);
        wait_cycles(1);
        check_output("press_lat19", 32'(LEDG[5]), 32'h1);
        check_output("hold_ledg", 32'(LEDG), 32'h35);
        wait_cycles(1);
        view_btn = 1'b1;

        mem_data = 16'h5678;
        mem_mode = 2'b00;
        wait_cycles(30);
        check_hex("frozen", 7'h79, 7'h24, 7'h30, 7'h19);
        check_output("frozen_hold", 32'(LEDG[5]), 32'h1);

        press_button(5);
        wait_cycles(30);
        check_output("glitch_hold", 32'(LEDG[5]), 32'h1);
        check_output("glitch_hex0", 32'(HEX0), 32'h19);

        press_button(20);
        wait_cycles(30);
        check_output("unhold", 32'(LEDG[5]), 32'h0);
        check_hex("unhold", 7'h7F, 7'h7F, 7'h78, 7'h00);

        press_button(20);
        wait_cycles(30);
        check_output("rehold", 32'(LEDG[5]), 32'h1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_hex("midhold_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check_output("midhold_reset_ledg", 32'(LEDG), 32'h00);
        check_output("midhold_reset_ledr", 32'(LEDR), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_hold", 32'(LEDG[5]), 32'h0);
        check_output("post_reset_sync_word", 32'(HEX3), 32'h12);
        check_output("post_reset_ledr", 32'(LEDR), 32'h0009);
        wait_cycles(2);
        check_output("post_reset_byte", 32'(HEX3), 32'h7F);
        check_output("post_reset_byte_hex0", 32'(HEX0), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
